// File: rtl/registro_pipeline_seq.sv
// Sequencer for the 2-stage ADC sample register: paces conversions, pulses shift_en, presents q_out.
// Latency: adc_start on the registered period tick; shift_en one cycle after adc_done; out_valid one cycle after shift_en.
// Backpressure: out_valid holds with no further shifts until out_ready; ticks arriving while busy are dropped and flagged.
module registro_pipeline_seq #(
    parameter int DIV_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [DIV_W-1:0] period,
    input  logic             flush,
    input  logic             clear_err,
    output logic             adc_start,
    input  logic             adc_done,
    output logic             shift_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             primed,
    output logic             timeout_err,
    output logic             overrun_err
);

    typedef enum logic [1:0] {IDLE, WAIT_ADC, SHIFT, PRESENT} state_t;

    // wait_cnt counts clocks since adc_start (1 in the first WAIT_ADC cycle)
    localparam logic [15:0] WAIT_LIM = (TIMEOUT > 1) ? 16'(TIMEOUT - 1) : 16'd1;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] tick_cnt, period_m1;
    logic             tick_q, tick, flush_q;
    logic [15:0]      wait_cnt, wait_cnt_nxt;
    logic [1:0]       fill, fill_nxt;
    logic             timeout_set, overrun_set;

    assign period_m1 = (period == '0) ? '0 : period - DIV_W'(1);
    assign tick      = tick_q & run;
    assign primed    = (fill == 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
            tick_q   <= 1'b0;
        end else if (!run) begin
            tick_cnt <= '0;
            tick_q   <= 1'b0;
        end else if (tick_cnt >= period_m1) begin
            tick_cnt <= '0;
            tick_q   <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
            tick_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fill        <= 2'd0;
            wait_cnt    <= 16'd0;
            flush_q     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            fill        <= fill_nxt;
            wait_cnt    <= wait_cnt_nxt;
            flush_q     <= flush;
            timeout_err <= timeout_set | (timeout_err & ~clear_err);
            overrun_err <= overrun_set | (overrun_err & ~clear_err);
        end
    end

    always_comb begin
        state_nxt    = state;
        fill_nxt     = fill;
        wait_cnt_nxt = wait_cnt;
        adc_start    = 1'b0;
        shift_en     = 1'b0;
        out_valid    = 1'b0;
        timeout_set  = 1'b0;
        overrun_set  = tick && (state != IDLE);

        case (state)
            IDLE: begin
                wait_cnt_nxt = 16'd0;
                // no new conversion in a flush cycle or the cycle after it
                if (tick && !flush && !flush_q) begin
                    adc_start    = 1'b1;
                    wait_cnt_nxt = 16'd1;
                    state_nxt    = WAIT_ADC;
                end
            end
            WAIT_ADC: begin
                if (adc_done) begin
                    wait_cnt_nxt = 16'd0;
                    state_nxt    = SHIFT;
                end else if (wait_cnt >= WAIT_LIM) begin
                    wait_cnt_nxt = 16'd0;
                    timeout_set  = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (fill != 2'd2) begin
                    fill_nxt = fill + 2'd1;
                end
                state_nxt = (fill_nxt == 2'd2) ? PRESENT : IDLE;
            end
            PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (flush) begin
            state_nxt    = IDLE;
            fill_nxt     = 2'd0;
            wait_cnt_nxt = 16'd0;
            timeout_set  = 1'b0;
        end
    end

endmodule

// File: tb/tb_registro_pipeline_seq.sv
// Directed bench for registro_pipeline_seq with a model of the external 2-stage sample register.
module tb_registro_pipeline_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] period;
    logic        flush;
    logic        clear_err;
    logic        adc_start;
    logic        adc_done;
    logic        shift_en;
    logic        out_valid;
    logic        out_ready;
    logic        primed;
    logic        timeout_err;
    logic        overrun_err;

    logic [7:0]  adc_data;
    logic [7:0]  reg_s1, q_out;
    logic        shift_prev;
    int          viol = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    registro_pipeline_seq #(.DIV_W(16), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .period     (period),
        .flush      (flush),
        .clear_err  (clear_err),
        .adc_start  (adc_start),
        .adc_done   (adc_done),
        .shift_en   (shift_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .primed     (primed),
        .timeout_err(timeout_err),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    // external sample register: q_out is the value captured two enables earlier
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_s1 <= 8'h00;
            q_out  <= 8'h00;
        end else if (shift_en) begin
            reg_s1 <= adc_data;
            q_out  <= reg_s1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            shift_prev <= 1'b0;
        end else begin
            if (shift_en && (shift_prev || out_valid)) viol <= viol + 1;
            shift_prev <= shift_en;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // advance until adc_start is seen; expired budget shows up as a wrong count
    task automatic wait_start(input string tag, input int exp);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!adc_start && n < 60);
        check(tag, n, exp);
    endtask

    // called in the adc_start cycle; returns in the SHIFT cycle
    task automatic answer(input logic [7:0] d);
        cyc();
        cyc();
        adc_done = 1'b1;
        adc_data = d;
        cyc();
        adc_done = 1'b0;
    endtask

    initial begin
        int k;
        int bad;
        reset = 1'b1; run = 1'b0; period = 16'd10; flush = 1'b0; clear_err = 1'b0;
        adc_done = 1'b0; out_ready = 1'b1; adc_data = 8'h00;
        cyc();
        cyc();
        check("reset_outputs", {adc_start, shift_en, out_valid, primed, timeout_err, overrun_err}, 6'b0);

        // priming, cycle 0 = run rises
        reset = 1'b0; run = 1'b1;
        wait_start("first_start_at_10", 10);
        answer(8'h11);
        check("shift1", shift_en, 1'b1);
        cyc();
        check("no_valid_after_shift1", {out_valid, primed}, 2'b00);
        wait_start("second_start", 6);
        answer(8'h22);
        check("shift2", shift_en, 1'b1);
        cyc();
        check("valid_primed_after_shift2", {out_valid, primed}, 2'b11);
        check("q_is_first_sample", q_out, 8'h11);
        cyc();
        check("valid_drops_after_accept", out_valid, 1'b0);

        // backpressure
        out_ready = 1'b0;
        wait_start("bp_start", 5);
        answer(8'h33);
        cyc();
        check("bp_valid_q", {out_valid, q_out}, {1'b1, 8'h22});
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (!out_valid || shift_en || adc_start || q_out != 8'h22) bad++;
        end
        check("bp_hold_stable", bad, 0);
        check("bp_overrun", overrun_err, 1'b1);
        out_ready = 1'b1;
        cyc();
        check("bp_release_idle", out_valid, 1'b0);
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        check("overrun_cleared", overrun_err, 1'b0);

        // timeout: adc_done never arrives
        wait_start("to_start", 4);
        k = 0;
        do begin
            cyc();
            k++;
        end while (!timeout_err && k < 20);
        check("timeout_after_8", k, 8);
        check("timeout_fill_kept", primed, 1'b1);
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        check("timeout_cleared", timeout_err, 1'b0);
        wait_start("idle_after_timeout", 1);
        answer(8'h44);
        cyc();
        check("present_before_flush", {out_valid, q_out}, {1'b1, 8'h33});

        // flush in PRESENT, then a late adc_done
        out_ready = 1'b0; flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("flush_outputs", {out_valid, primed, adc_start}, 3'b000);
        adc_done = 1'b1;
        cyc();
        adc_done = 1'b0;
        check("late_done_no_shift", shift_en, 1'b0);
        cyc();
        check("late_done_no_shift2", shift_en, 1'b0);
        out_ready = 1'b1;
        wait_start("post_flush_start1", 3);
        answer(8'h55);
        cyc();
        check("post_flush_one_conv", {out_valid, primed}, 2'b00);
        wait_start("post_flush_start2", 6);
        answer(8'h66);
        cyc();
        check("post_flush_two_conv", {out_valid, primed, q_out}, {2'b11, 8'h55});
        cyc();
        check("no_errors_yet", {timeout_err, overrun_err}, 2'b00);

        // period = 0
        run = 1'b0;
        cyc();
        period = 16'd0; run = 1'b1;
        wait_start("p0_first_tick", 1);
        cyc();
        check("p0_first_tick_no_ovr", {overrun_err, adc_start}, 2'b00);
        cyc();
        check("p0_second_tick_ovr", overrun_err, 1'b1);
        adc_done = 1'b1; adc_data = 8'h77;
        cyc();
        adc_done = 1'b0;
        check("p0_shift_single_start", {shift_en, adc_start}, 2'b10);
        cyc();
        check("p0_present", {out_valid, q_out, adc_start}, {1'b1, 8'h66, 1'b0});
        run = 1'b0; clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        check("run_low_no_start", {adc_start, out_valid, overrun_err}, 3'b000);

        // period = 1
        period = 16'd1; run = 1'b1;
        wait_start("p1_first_tick", 1);
        cyc();
        check("p1_first_tick_no_ovr", {overrun_err, adc_start}, 2'b00);
        cyc();
        check("p1_second_tick_ovr", overrun_err, 1'b1);
        adc_done = 1'b1; adc_data = 8'h88;
        cyc();
        adc_done = 1'b0;
        check("p1_shift_single_start", {shift_en, adc_start}, 2'b10);
        cyc();
        check("p1_present", {out_valid, q_out}, {1'b1, 8'h77});
        cyc();
        check("p1_next_start", adc_start, 1'b1);
        period = 16'd10;
        cyc();

        // async reset while in WAIT_ADC
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {adc_start, shift_en, out_valid, primed, timeout_err, overrun_err}, 6'b0);
        cyc();
        cyc();
        reset = 1'b0;
        wait_start("start_after_reset", 10);

        check("shift_en_rules", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/registro_pipeline_seq.md
# registro_pipeline_seq

Sequencer for the 2-stage enabled sample register (`N`-bit, one `enable`, `q_out` = value captured two enables earlier) between the position ADC and the servo PWM/control logic. It paces ADC conversions from a programmable sample period and pulses the register enable once per completed conversion. It tracks pipeline fill and presents each valid register output to the downstream consumer with a valid/ready handshake. ADC timeouts and sample-period overruns are flagged.

## Interface
- `DIV_W`, 16: width of the sample-period counter and `period` input.
- `TIMEOUT`, 255: maximum clocks spent waiting for `adc_done` before abort (1..2^16-1).
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state, counters and flags.
- `run`  in  1  level; 1 = periodic sampling active.
- `period`  in  DIV_W  sample period in clocks; 0 treated as 1.
- `flush`  in  1  one-cycle pulse; empties pipeline bookkeeping.
- `clear_err`  in  1  one-cycle pulse; clears sticky flags.
- `adc_start`  out  1  one-cycle conversion request.
- `adc_done`  in  1  conversion complete; data valid at register input this cycle.
- `shift_en`  out  1  drives register `enable`; one-cycle pulse.
- `out_valid`  out  1  register `q_out` holds a new, valid sample.
- `out_ready`  in  1  consumer accepts when `out_valid & out_ready`.
- `primed`  out  1  at least two shifts since reset/flush.
- `timeout_err`  out  1  sticky; ADC failed to answer.
- `overrun_err`  out  1  sticky; period tick arrived while busy.

## Operation
- Reset values: all outputs 0, FSM = IDLE, fill = 0, tick counter = 0, wait counter = 0.
- Tick counter, when `run`=1: it counts up to `max(period,1)-1`, then issues `tick` and wraps to 0. When `run`=0 it holds at 0 and no ticks are issued. The first tick occurs `period` clocks after `run` rises.
- FSM states: IDLE, WAIT_ADC, SHIFT, PRESENT.
- IDLE: on `tick`, assert `adc_start` for that cycle and go to WAIT_ADC.
- WAIT_ADC: the wait counter increments each cycle.
  - `adc_done`=1: go to SHIFT.
  - Wait counter reaches `TIMEOUT` without `adc_done`: set `timeout_err`, no shift, go to IDLE.
- SHIFT: lasts one cycle. `shift_en`=1 and fill increments, saturating at 2.
  - If the new fill is 2, go to PRESENT.
  - Otherwise go to IDLE (priming; no output).
- PRESENT: `out_valid`=1. On `out_ready`=1, go to IDLE. `out_valid` drops the next cycle.
- `primed` equals (fill == 2).
- Overrun: a `tick` in any state other than IDLE sets `overrun_err`. The tick is dropped, with no queuing and no second `adc_start`.
- `flush` has highest priority:
  - fill goes to 0 and the FSM goes to IDLE.
  - `out_valid`, `shift_en` and `adc_start` are 0 in the following cycle.
  - A conversion in flight is abandoned; a late `adc_done` in IDLE is ignored.
  - The tick counter is unaffected.
- `adc_done` outside WAIT_ADC is ignored.
- `run` falling mid-transaction: the current transaction completes normally and no new ticks are issued.
- `clear_err` clears both sticky flags. If a flag's set condition occurs in the same cycle, set wins.
- Reset mid-operation: everything returns to reset values immediately and asynchronously. The register itself is reset by the same `reset`.

## Timing
- `tick` to `adc_start`: same cycle when in IDLE (combinational from tick and state, but registered tick).
- `adc_done` in cycle t: SHIFT in t+1 (`shift_en`=1). The register captures at the end of t+1, so `q_out` is new from t+2.
- `out_valid` asserts in t+2 (the PRESENT entry cycle), exactly when `q_out` reflects the shift.
- The first valid output needs two completed conversions after reset/flush. The sample on `q_out` is the one from the previous conversion; this one-sample latency is intrinsic to the register.
- Minimum cycle per sample with immediate `adc_done` and `out_ready`=1: tick, WAIT_ADC, SHIFT, PRESENT = 4 clocks. Any `period` < 4 guarantees overruns.
- `shift_en` is never asserted more than one consecutive cycle.
- `shift_en` is never asserted while `out_valid`=1, so the held output is stable until accepted.

## Test plan
- Reset/priming: `period`=10, `run`=1, ADC answers 2 cycles after `adc_start`, `out_ready`=1.
  - First `adc_start` at clock 10; no `out_valid` after the first shift.
  - `primed`=1 and one `out_valid` after the second shift.
  - `q_out` equals the first sample.
- Backpressure: after priming, hold `out_ready`=0 for 30 clocks with `period`=10.
  - `out_valid` stays 1 and `q_out` stays stable; no `shift_en`; `overrun_err`=1.
  - Raising `out_ready` returns the FSM to IDLE.
- Timeout: `TIMEOUT`=8, never assert `adc_done`.
  - `timeout_err`=1 exactly 8 clocks after `adc_start`; FSM is back in IDLE; fill unchanged.
  - `clear_err` clears the flag.
- Flush: assert `flush` during PRESENT, then deliver a late `adc_done`.
  - `out_valid`=0 next cycle; `primed`=0; the late `adc_done` produces no `shift_en`.
  - Two new conversions are needed before the next `out_valid`.
- Boundary `period`=0 and `period`=1: `tick` every clock; `overrun_err` sets on the second tick; exactly one `adc_start` per transaction.
- Async reset mid-WAIT_ADC: all outputs 0 immediately; after release, the first `adc_start` comes `period` clocks later.
